// File: rtl/memory_access_ctrl_pkg.sv
// Shared pipeline definitions for the memory stage: MemtoReg encodings, FSM states, timeout default.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package memory_access_ctrl_pkg;

  // Result-select encodings carried in MemtoRegM
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  // Memory-stage controller states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Cycles allowed in BUSY without an ack before the access is abandoned
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/memory_access_ctrl.sv
// Memory-stage controller: turns EX/MEM load/store into a req/ack data-memory access, flags misalign/timeout.
// Latency: 3 cycles per access with ack on the first BUSY cycle, +1 per extra ack-wait cycle; 2 cycles on misalign.
// Backpressure: o_StallM freezes the upstream pipeline from the issuing IDLE cycle until DONE; memory paces via i_DMemAck.
module memory_access_ctrl
  import memory_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic                     i_MemWriteM,
  input  logic [1:0]               i_MemtoRegM,
  input  logic                     i_ErrClr,
  input  logic                     i_DMemAck,
  input  logic [DATA_WIDTH-1:0]    i_DMemRData,
  output logic                     o_DMemReq,
  output logic                     o_DMemWe,
  output logic [ADDRESS_WIDTH-1:0] o_DMemAddr,
  output logic [DATA_WIDTH-1:0]    o_DMemWData,
  output logic                     o_StallM,
  output logic [DATA_WIDTH-1:0]    o_ReadDataM,
  output logic                     o_BusErr
);

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic mem_op;
  logic aligned;
  logic issue;
  logic misalign_hit;
  logic ack_hit;
  logic timeout_hit;

  // A store takes priority when both store and load are flagged
  assign mem_op       = i_MemWriteM | (i_MemtoRegM == MEMTOREG_MEM);
  assign aligned      = (i_ALUOutM[1:0] == 2'b00);
  assign issue        = (state_q == ST_IDLE) && mem_op && aligned;
  assign misalign_hit = (state_q == ST_IDLE) && mem_op && !aligned;
  // Ack is only meaningful while an access is outstanding
  assign ack_hit      = (state_q == ST_BUSY) && i_DMemAck;
  assign timeout_hit  = (state_q == ST_BUSY) && !i_DMemAck &&
                        (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: misaligned ops skip BUSY, DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op) state_d = aligned ? ST_BUSY : ST_DONE;
      ST_BUSY: if (ack_hit || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall from the issuing cycle through BUSY; released in DONE so the pipeline advances
  always_comb begin
    o_StallM = 1'b0;
    case (state_q)
      ST_IDLE: o_StallM = mem_op;
      ST_BUSY: o_StallM = 1'b1;
      default: o_StallM = 1'b0;
    endcase
  end

  // Ack-wait counter, cleared while idle and advanced on every unacked BUSY cycle
  always_ff @(posedge i_CLK) begin
    if (i_RST)                             cnt_q <= '0;
    else if (state_q == ST_IDLE)           cnt_q <= '0;
    else if (state_q == ST_BUSY && !i_DMemAck) cnt_q <= cnt_q + CNT_WIDTH'(1);
  end

  // Request port: captured at issue, held stable until ack or timeout
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_DMemReq   <= 1'b0;
      o_DMemWe    <= 1'b0;
      o_DMemAddr  <= '0;
      o_DMemWData <= '0;
    end else if (issue) begin
      o_DMemReq   <= 1'b1;
      o_DMemWe    <= i_MemWriteM;
      o_DMemAddr  <= ADDRESS_WIDTH'(i_ALUOutM);
      o_DMemWData <= i_WriteDataM;
    end else if (ack_hit || timeout_hit) begin
      o_DMemReq   <= 1'b0;
    end
  end

  // Load result: memory data on a load ack, zero on any error, otherwise held
  always_ff @(posedge i_CLK) begin
    if (i_RST)                      o_ReadDataM <= '0;
    else if (misalign_hit || timeout_hit) o_ReadDataM <= '0;
    else if (ack_hit && !o_DMemWe)  o_ReadDataM <= i_DMemRData;
  end

  // Sticky bus error; a new error beats a simultaneous clear
  always_ff @(posedge i_CLK) begin
    if (i_RST)                            o_BusErr <= 1'b0;
    else if (misalign_hit || timeout_hit) o_BusErr <= 1'b1;
    else if (i_ErrClr)                    o_BusErr <= 1'b0;
  end

endmodule
